// File: rtl/preg_freelist.sv
`default_nettype none
// ============================================================================
// Module   : preg_freelist
// Purpose  : Physical-register free list for rename; 2 allocs + 2 frees/cycle.
// Revision : 1.0
// ============================================================================
module preg_freelist #(
  parameter  int PREG_COUNT = 64,
  parameter  int ARCH_COUNT = 32,
  localparam int PREG_W     = $clog2(PREG_COUNT),
  localparam int DEPTH      = PREG_COUNT - ARCH_COUNT,
  localparam int PTR_W      = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alloc_req0_i,
  input  logic              alloc_req1_i,
  output logic              alloc_ready_o,
  output logic [PREG_W-1:0] alloc_preg0_o,
  output logic [PREG_W-1:0] alloc_preg1_o,
  output logic              bt_alloc_en0_o,
  output logic              bt_alloc_en1_o,
  output logic [PREG_W-1:0] bt_alloc_addr0_o,
  output logic [PREG_W-1:0] bt_alloc_addr1_o,
  input  logic              free_en0_i,
  input  logic              free_en1_i,
  input  logic [PREG_W-1:0] free_preg0_i,
  input  logic [PREG_W-1:0] free_preg1_i,
  input  logic [1:0]        commit_alloc_cnt_i,
  input  logic              flush_i,
  output logic [PTR_W-1:0]  free_count_o,
  output logic              overflow_err_o
);

  localparam int IDX_W = PTR_W - 1;

  logic [PREG_W-1:0] entries_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W-1:0]  arch_head_q, arch_head_d;
  logic              overflow_q, overflow_d;

  logic [PTR_W-1:0]  free_count;
  logic [PTR_W-1:0]  head_p1;
  logic [PTR_W-1:0]  count_mid;
  logic [PTR_W-1:0]  wr_ptr1;
  logic [1:0]        n_req;
  logic              fire0, fire1;
  logic              accept0, accept1;

  always_comb begin
    free_count    = tail_q - head_q;
    head_p1       = head_q + PTR_W'(1);
    alloc_preg0_o = entries_q[head_q[IDX_W-1:0]];
    alloc_preg1_o = entries_q[head_p1[IDX_W-1:0]];

    // All-or-nothing grant; req1 only counts alongside req0.
    n_req         = {1'b0, alloc_req0_i} + {1'b0, alloc_req0_i & alloc_req1_i};
    alloc_ready_o = !flush_i && (free_count >= PTR_W'(n_req));
    fire0         = alloc_req0_i && alloc_ready_o;
    fire1         = fire0 && alloc_req1_i;

    // Overflow is judged against the pre-edge count, free0 before free1.
    accept0   = free_en0_i && (free_count != PTR_W'(DEPTH));
    count_mid = free_count + PTR_W'(accept0);
    accept1   = free_en1_i && (count_mid != PTR_W'(DEPTH));
    wr_ptr1   = tail_q + PTR_W'(accept0);
    tail_d    = wr_ptr1 + PTR_W'(accept1);

    overflow_d  = overflow_q | (free_en0_i & ~accept0) | (free_en1_i & ~accept1);
    arch_head_d = arch_head_q + PTR_W'(commit_alloc_cnt_i);
    if (flush_i) begin
      head_d = arch_head_q + PTR_W'(commit_alloc_cnt_i);
    end else begin
      head_d = head_q + PTR_W'(fire0) + PTR_W'(fire1);
    end
  end

  assign bt_alloc_en0_o   = fire0;
  assign bt_alloc_en1_o   = fire1;
  assign bt_alloc_addr0_o = alloc_preg0_o;
  assign bt_alloc_addr1_o = alloc_preg1_o;
  assign free_count_o     = free_count;
  assign overflow_err_o   = overflow_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q      <= '0;
      arch_head_q <= '0;
      tail_q      <= PTR_W'(DEPTH);
      overflow_q  <= 1'b0;
    end else begin
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= PREG_W'(ARCH_COUNT + i);
      end
    end else begin
      if (accept0) entries_q[tail_q[IDX_W-1:0]]  <= free_preg0_i;
      if (accept1) entries_q[wr_ptr1[IDX_W-1:0]] <= free_preg1_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_preg_freelist.sv
`default_nettype none
// ============================================================================
// Module   : tb_preg_freelist
// Purpose  : Table-driven directed bench for preg_freelist.
// Revision : 1.0
// ============================================================================
module tb_preg_freelist;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       alloc_req0, alloc_req1, alloc_ready;
  logic [5:0] alloc_preg0, alloc_preg1;
  logic       bt_en0, bt_en1;
  logic [5:0] bt_addr0, bt_addr1;
  logic       free_en0, free_en1;
  logic [5:0] free_preg0, free_preg1;
  logic [1:0] commit_cnt;
  logic       flush;
  logic [5:0] free_count;
  logic       overflow_err;

  always #5 clock = ~clock;

  preg_freelist #(.PREG_COUNT(64), .ARCH_COUNT(32)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .alloc_req0_i       (alloc_req0),
    .alloc_req1_i       (alloc_req1),
    .alloc_ready_o      (alloc_ready),
    .alloc_preg0_o      (alloc_preg0),
    .alloc_preg1_o      (alloc_preg1),
    .bt_alloc_en0_o     (bt_en0),
    .bt_alloc_en1_o     (bt_en1),
    .bt_alloc_addr0_o   (bt_addr0),
    .bt_alloc_addr1_o   (bt_addr1),
    .free_en0_i         (free_en0),
    .free_en1_i         (free_en1),
    .free_preg0_i       (free_preg0),
    .free_preg1_i       (free_preg1),
    .commit_alloc_cnt_i (commit_cnt),
    .flush_i            (flush),
    .free_count_o       (free_count),
    .overflow_err_o     (overflow_err)
  );

  typedef struct {
    bit       rst;
    bit       r0, r1, f0, f1, fl;
    bit [5:0] fp0, fp1;
    bit [1:0] cac;
    bit       e_rdy, e_en0, e_en1, e_ovf;
    bit [5:0] e_p0, e_p1, e_fc;
  } vec_t;

  vec_t vq[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic add(input bit rst, input bit r0, input bit r1,
                     input bit f0, input int fp0, input bit f1, input int fp1,
                     input int cac, input bit fl,
                     input bit rdy, input int p0, input int p1,
                     input bit e0, input bit e1, input int fc, input bit ovf);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.f0 = f0; v.f1 = f1; v.fl = fl;
    v.fp0 = 6'(fp0); v.fp1 = 6'(fp1); v.cac = 2'(cac);
    v.e_rdy = rdy; v.e_en0 = e0; v.e_en1 = e1; v.e_ovf = ovf;
    v.e_p0 = 6'(p0); v.e_p1 = 6'(p1); v.e_fc = 6'(fc);
    vq.push_back(v);
  endtask

  task automatic check(input vec_t v, input int idx);
    n_vec++;
    if (alloc_ready !== v.e_rdy || alloc_preg0 !== v.e_p0 || alloc_preg1 !== v.e_p1 ||
        bt_en0 !== v.e_en0 || bt_en1 !== v.e_en1 || bt_addr0 !== v.e_p0 ||
        bt_addr1 !== v.e_p1 || free_count !== v.e_fc || overflow_err !== v.e_ovf) begin
      n_fail++;
      $display("FAIL vec%0d: got rdy=%0b p0=%0d p1=%0d en=%0b%0b addr=%0d/%0d fc=%0d ovf=%0b ; want rdy=%0b p0=%0d p1=%0d en=%0b%0b fc=%0d ovf=%0b",
               idx, alloc_ready, alloc_preg0, alloc_preg1, bt_en0, bt_en1, bt_addr0, bt_addr1,
               free_count, overflow_err, v.e_rdy, v.e_p0, v.e_p1, v.e_en0, v.e_en1, v.e_fc, v.e_ovf);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    {alloc_req0, alloc_req1, free_en0, free_en1, flush} = '0;
    free_preg0 = '0; free_preg1 = '0; commit_cnt = '0;

    // Phase A: drain in order, free-count boundary, free pair, full-lap wrap.
    add(1,0,0, 0,0,0,0, 0,0, 1,32,33,0,0,32,0);
    for (int k = 0; k < 16; k++)
      add(0,1,1, 0,0,0,0, 0,0, 1,32+2*k,33+2*k,1,1,32-2*k,0);
    add(0,1,1, 0,0,0,0, 0,0, 0,32,33,0,0,0,0);
    add(0,0,0, 1,5,0,0, 0,0, 1,32,33,0,0,0,0);
    add(0,1,1, 0,0,0,0, 0,0, 0,5,33,0,0,1,0);
    add(0,1,0, 0,0,0,0, 0,0, 1,5,33,1,0,1,0);
    add(0,0,0, 1,5,1,9, 0,0, 1,33,34,0,0,0,0);
    add(0,1,1, 0,0,0,0, 0,0, 1,5,9,1,1,2,0);
    for (int k = 0; k < 16; k++)
      add(0,0,0, 1,10+2*k,1,11+2*k, 0,0, 1,(k==0)?35:10,(k==0)?36:11,0,0,2*k,0);
    for (int k = 0; k < 16; k++)
      add(0,1,1, 0,0,0,0, 0,0, 1,10+2*k,11+2*k,1,1,32-2*k,0);
    add(0,1,0, 0,0,0,0, 0,0, 0,10,11,0,0,0,0);

    // Phase B: commit then flush restores head; flush with commit and free.
    add(1,1,1, 0,0,0,0, 0,0, 1,32,33,1,1,32,0);
    add(0,1,1, 0,0,0,0, 0,0, 1,34,35,1,1,30,0);
    add(0,1,1, 0,0,0,0, 0,0, 1,36,37,1,1,28,0);
    add(0,0,0, 0,0,0,0, 2,0, 1,38,39,0,0,26,0);
    add(0,1,1, 0,0,0,0, 0,1, 0,38,39,0,0,26,0);
    add(0,0,0, 0,0,0,0, 0,0, 1,34,35,0,0,30,0);
    add(0,1,0, 1,7,0,0, 1,1, 0,34,35,0,0,30,0);
    add(0,0,0, 0,0,0,0, 0,0, 1,35,36,0,0,30,0);

    // Phase C: overflow while full, alloc+free while full, free1 overflow.
    add(1,0,1, 0,0,0,0, 0,0, 1,32,33,0,0,32,0);
    add(0,0,0, 1,5,0,0, 0,0, 1,32,33,0,0,32,0);
    add(0,0,0, 0,0,0,0, 0,0, 1,32,33,0,0,32,1);
    add(1,1,0, 1,6,0,0, 0,0, 1,32,33,1,0,32,0);
    add(0,0,0, 0,0,0,0, 0,0, 1,33,34,0,0,31,1);
    add(1,1,0, 0,0,0,0, 0,0, 1,32,33,1,0,32,0);
    add(0,0,0, 1,40,1,41, 0,0, 1,33,34,0,0,31,0);
    add(0,0,0, 0,0,0,0, 0,0, 1,33,34,0,0,32,1);

    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clock);
      if (vq[i].rst) begin
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
      alloc_req0 = vq[i].r0;  alloc_req1 = vq[i].r1;
      free_en0   = vq[i].f0;  free_preg0 = vq[i].fp0;
      free_en1   = vq[i].f1;  free_preg1 = vq[i].fp1;
      commit_cnt = vq[i].cac; flush      = vq[i].fl;
      #2 check(vq[i], i);
    end

    // Asynchronous reset takes effect with no clock edge.
    @(negedge clock);
    {alloc_req0, alloc_req1, free_en0, free_en1, flush} = '0;
    commit_cnt = '0;
    #1 reset_n = 1'b0;
    #1 begin
      vec_t v;
      v.e_rdy = 1; v.e_p0 = 32; v.e_p1 = 33; v.e_en0 = 0; v.e_en1 = 0;
      v.e_fc = 32; v.e_ovf = 0;
      check(v, 999);
    end
    reset_n = 1'b1;

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
